// File: rtl/game_pkg.sv
// Shared types and winner codes for the NxN game controller and its line checker.
package game_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b10,
        O     = 2'b11
    } cellStateType;

    typedef enum logic [2:0] {
        START,
        PLAYER1,
        PLAYER2,
        CHECK,
        END
    } statetype;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_DRAW = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_P2   = 2'b11;

    function automatic cellStateType moverSymbol(input logic isPlayer1);
        return isPlayer1 ? X : O;
    endfunction

endpackage

// File: rtl/nxn_win_check.sv
// Combinational N-in-a-row detector: rows, columns and both diagonals of the board
// are matched against one symbol.
module nxn_win_check import game_pkg::*; #(
    parameter int N = 3
) (
    input  logic [2*N*N-1:0] board,
    input  cellStateType     symbol,
    output logic             lineFound
);

    logic [N-1:0] rowHit, colHit, diagMatch, antiMatch;

    for (genvar i = 0; i < N; i++) begin : gLine
        logic [N-1:0] rowMatch, colMatch;
        for (genvar j = 0; j < N; j++) begin : gCell
            assign rowMatch[j] = board[2*(i*N+j) +: 2] == symbol;
            assign colMatch[j] = board[2*(j*N+i) +: 2] == symbol;
        end
        assign rowHit[i]    = &rowMatch;
        assign colHit[i]    = &colMatch;
        assign diagMatch[i] = board[2*(i*N+i) +: 2] == symbol;
        assign antiMatch[i] = board[2*(i*N+N-1-i) +: 2] == symbol;
    end

    // An EMPTY symbol would match a blank board, so it never counts as a line.
    assign lineFound = (symbol != EMPTY) &&
                       ((|rowHit) || (|colHit) || (&diagMatch) || (&antiMatch));

endmodule

// File: rtl/nxn_game_controller.sv
// NxN N-in-a-row game controller: owns the board, validates moves, alternates turns,
// detects win/draw. Optional per-turn timeout under GAME_MOVE_TIMEOUT_EN.
module nxn_game_controller import game_pkg::*; #(
    parameter  int N              = 3,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int NN             = N * N,
    localparam int AW             = $clog2(N * N),
    localparam int MCW            = $clog2(N * N + 1)
) (
    input  logic            ph1,
    input  logic            reset,
    input  logic            isPlayer1Start,
    input  logic            newGame,
    input  logic            playerWrite,
    input  logic [AW-1:0]   playerInput,
    output logic [2*NN-1:0] gBoard,
    output logic            currentPlayer,
    output logic            moveAccept,
    output logic            moveError,
    output logic [MCW-1:0]  moveCount,
    output logic            gameIsDone,
    output logic [1:0]      winner
);

    statetype        state, stateNext;
    logic [2*NN-1:0] boardNext;
    logic [MCW-1:0]  moveCountNext;
    logic [1:0]      winnerNext;
    logic            doneNext, acceptNext, errorNext, playerNext;
    logic            lineFound, timeUp, legalMove, inTurn;
    logic [1:0]      selCell;
    cellStateType    checkSym, writeSym;

    assign inTurn   = (state == PLAYER1) || (state == PLAYER2);
    assign checkSym = moverSymbol(currentPlayer);
    assign writeSym = moverSymbol(state == PLAYER1);

    nxn_win_check #(.N(N)) uWinCheck (
        .board     (gBoard),
        .symbol    (checkSym),
        .lineFound (lineFound)
    );

    // Indices past N*N-1 fall through with selCell EMPTY and are rejected by the range test.
    always_comb begin
        selCell = EMPTY;
        for (int i = 0; i < NN; i++)
            if (int'(playerInput) == i) selCell = gBoard[2*i +: 2];
    end

    assign legalMove = (int'(playerInput) < NN) && (selCell == EMPTY);

`ifdef GAME_MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] turnCnt;

    // Clears on any entry into a turn state, including a timeout hand-over.
    always_ff @(posedge ph1) begin
        if (reset)
            turnCnt <= '0;
        else if (inTurn && stateNext == state)
            turnCnt <= turnCnt + TW'(1);
        else
            turnCnt <= '0;
    end

    assign timeUp = inTurn && (turnCnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
    assign timeUp           = 1'b0;
`endif

    always_comb begin
        stateNext     = state;
        boardNext     = gBoard;
        moveCountNext = moveCount;
        winnerNext    = winner;
        doneNext      = gameIsDone;
        acceptNext    = 1'b0;
        errorNext     = 1'b0;
        playerNext    = currentPlayer;
        case (state)
            START: begin
                stateNext  = isPlayer1Start ? PLAYER1 : PLAYER2;
                playerNext = isPlayer1Start;
            end
            PLAYER1, PLAYER2: begin
                // A legal move beats a timeout landing on the same cycle.
                if (playerWrite && legalMove) begin
                    for (int i = 0; i < NN; i++)
                        if (int'(playerInput) == i) boardNext[2*i +: 2] = writeSym;
                    moveCountNext = moveCount + MCW'(1);
                    acceptNext    = 1'b1;
                    stateNext     = CHECK;
                end else begin
                    errorNext = playerWrite | timeUp;
                    if (timeUp) begin
                        stateNext  = (state == PLAYER1) ? PLAYER2 : PLAYER1;
                        playerNext = (state == PLAYER2);
                    end
                end
            end
            CHECK: begin
                if (lineFound) begin
                    winnerNext = currentPlayer ? WIN_P1 : WIN_P2;
                    doneNext   = 1'b1;
                    stateNext  = END;
                end else if (moveCount == MCW'(NN)) begin
                    winnerNext = WIN_DRAW;
                    doneNext   = 1'b1;
                    stateNext  = END;
                end else begin
                    stateNext  = currentPlayer ? PLAYER2 : PLAYER1;
                    playerNext = ~currentPlayer;
                end
            end
            END: begin
                if (newGame) begin
                    boardNext     = '0;
                    moveCountNext = '0;
                    winnerNext    = WIN_NONE;
                    doneNext      = 1'b0;
                    stateNext     = START;
                end
            end
            default: stateNext = START;
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state         <= START;
            gBoard        <= '0;
            moveCount     <= '0;
            winner        <= WIN_NONE;
            gameIsDone    <= 1'b0;
            moveAccept    <= 1'b0;
            moveError     <= 1'b0;
            currentPlayer <= 1'b0;
        end else begin
            state         <= stateNext;
            gBoard        <= boardNext;
            moveCount     <= moveCountNext;
            winner        <= winnerNext;
            gameIsDone    <= doneNext;
            moveAccept    <= acceptNext;
            moveError     <= errorNext;
            currentPlayer <= playerNext;
        end
    end

endmodule

// File: tb/tb_nxn_game_controller.sv
// Bench for nxn_game_controller: directed vector table and random play against a
// rule-level game model (N=3), plus a hand sequence on an N=4 instance.
module tb_nxn_game_controller;

    localparam int N = 3, NN = 9, AW = 4, MCW = 4;

    logic ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    logic            reset = 1'b1, isPlayer1Start = 1'b1, newGame = 1'b0, playerWrite = 1'b0;
    logic [AW-1:0]   playerInput = '0;
    logic [2*NN-1:0] gBoard;
    logic            currentPlayer, moveAccept, moveError, gameIsDone;
    logic [MCW-1:0]  moveCount;
    logic [1:0]      winner;

    nxn_game_controller #(.N(N)) dut (
        .ph1(ph1), .reset(reset), .isPlayer1Start(isPlayer1Start), .newGame(newGame),
        .playerWrite(playerWrite), .playerInput(playerInput), .gBoard(gBoard),
        .currentPlayer(currentPlayer), .moveAccept(moveAccept), .moveError(moveError),
        .moveCount(moveCount), .gameIsDone(gameIsDone), .winner(winner)
    );

    logic        reset4 = 1'b1, p1s4 = 1'b1, ng4 = 1'b0, pw4 = 1'b0;
    logic [3:0]  pi4 = '0;
    logic [31:0] board4;
    logic        cp4, acc4, err4, done4;
    logic [4:0]  cnt4;
    logic [1:0]  win4;

    nxn_game_controller #(.N(4), .TIMEOUT_CYCLES(8)) dut4 (
        .ph1(ph1), .reset(reset4), .isPlayer1Start(p1s4), .newGame(ng4),
        .playerWrite(pw4), .playerInput(pi4), .gBoard(board4),
        .currentPlayer(cp4), .moveAccept(acc4), .moveError(err4),
        .moveCount(cnt4), .gameIsDone(done4), .winner(win4)
    );

    int nVec = 0, nFail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int rst, pw, pi, ng, p1s;
        int acc, err, cp, done, cnt, win;
        logic [2*NN-1:0] board;
    } vec_t;

    vec_t            vecs[$];
    logic [2*NN-1:0] tBoard = '0;

    function automatic void add(input int rst, input int pw, input int pi, input int ng,
                                input int p1s, input int acc, input int err, input int cp,
                                input int done, input int cnt, input int win);
        vec_t v;
        v.rst = rst; v.pw = pw; v.pi = pi; v.ng = ng; v.p1s = p1s;
        v.acc = acc; v.err = err; v.cp = cp; v.done = done; v.cnt = cnt; v.win = win;
        v.board = tBoard;
        vecs.push_back(v);
    endfunction

    function automatic void put(input int i, input logic [1:0] c);
        tBoard[2*i +: 2] = c;
    endfunction

    // Nine-move game starting with X; the final check row carries lastWin.
    function automatic void addGame(input int mv[9], input int lastWin);
        for (int k = 0; k < 9; k++) begin
            put(mv[k], (k % 2 == 0) ? 2'b10 : 2'b11);
            add(0, 1, mv[k], 0, 1, 1, 0, (k % 2 == 0) ? 1 : 0, 0, k + 1, 0);
            if (k < 8) add(0, 0, 0, 0, 1, 0, 0, (k % 2 == 1) ? 1 : 0, 0, k + 1, 0);
            else       add(0, 0, 0, 0, 1, 0, 0, 1, 1, 9, lastWin);
        end
        add(0, 1, 0, 0, 1, 0, 0, 1, 1, 9, lastWin);
        tBoard = '0;
        add(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    endfunction

    // ---------------- rule-level reference model ----------------
    int         mCell[NN];
    bit         mP1, mStart, mTurn, mChk, mDone, mAcc, mErr;
    int         mCnt;
    logic [1:0] mWin;

    function automatic bit hasLine(input int s);
        bit all;
        for (int r = 0; r < N; r++) begin
            all = 1;
            for (int c = 0; c < N; c++) if (mCell[r*N+c] != s) all = 0;
            if (all) return 1;
            all = 1;
            for (int c = 0; c < N; c++) if (mCell[c*N+r] != s) all = 0;
            if (all) return 1;
        end
        all = 1;
        for (int i = 0; i < N; i++) if (mCell[i*N+i] != s) all = 0;
        if (all) return 1;
        all = 1;
        for (int i = 0; i < N; i++) if (mCell[i*N+N-1-i] != s) all = 0;
        return all;
    endfunction

    function automatic void mClear();
        for (int i = 0; i < NN; i++) mCell[i] = 0;
        mCnt = 0; mWin = 2'b00; mDone = 0; mStart = 1; mTurn = 0; mChk = 0;
    endfunction

    function automatic void mStep(input bit rst, input bit pw, input int pi, input bit ng,
                                  input bit p1s);
        mAcc = 0; mErr = 0;
        if (rst) begin
            mClear(); mP1 = 0;
        end else if (mStart) begin
            mStart = 0; mTurn = 1; mP1 = p1s;
        end else if (mTurn) begin
            if (pw) begin
                if (pi < NN) begin
                    if (mCell[pi] == 0) begin
                        mCell[pi] = mP1 ? 1 : 2; mCnt++; mAcc = 1; mTurn = 0; mChk = 1;
                    end else mErr = 1;
                end else mErr = 1;
            end
        end else if (mChk) begin
            mChk = 0;
            if (hasLine(mP1 ? 1 : 2)) begin mWin = mP1 ? 2'b10 : 2'b11; mDone = 1; end
            else if (mCnt == NN)      begin mWin = 2'b01; mDone = 1; end
            else                      begin mP1 = !mP1; mTurn = 1; end
        end else if (mDone && ng) begin
            mClear();
        end
    endfunction

    function automatic logic [2*NN-1:0] mBoard();
        logic [2*NN-1:0] b = '0;
        for (int i = 0; i < NN; i++)
            b[2*i +: 2] = (mCell[i] == 1) ? 2'b10 : (mCell[i] == 2) ? 2'b11 : 2'b00;
        return b;
    endfunction

    task automatic step4(input bit pw, input int pi);
        pw4 = pw; pi4 = 4'(pi);
        @(posedge ph1); #1;
    endtask

    initial begin
        int drawGame[9], winLastGame[9];
        drawGame    = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        winLastGame = '{0, 1, 2, 4, 3, 5, 7, 8, 6};

        // fields: rst pw pi ng p1s | acc err cp done cnt win
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        put(0, 2'b10); add(0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        put(4, 2'b11); add(0, 1, 4, 0, 1, 1, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0);
        add(0, 1, 4, 0, 1, 0, 1, 1, 0, 2, 0);
        add(0, 1, 9, 0, 1, 0, 1, 1, 0, 2, 0);
        add(0, 1, 15, 0, 1, 0, 1, 1, 0, 2, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0);
        put(1, 2'b10); add(0, 1, 1, 0, 1, 1, 0, 1, 0, 3, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0);
        put(3, 2'b11); add(0, 1, 3, 0, 1, 1, 0, 0, 0, 4, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, 4, 0);
        put(2, 2'b10); add(0, 1, 2, 0, 1, 1, 0, 1, 0, 5, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 1, 5, 2);
        add(0, 1, 5, 0, 1, 0, 0, 1, 1, 5, 2);
        tBoard = '0; add(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        addGame(drawGame, 1);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        addGame(winLastGame, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        put(0, 2'b11); add(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tBoard = '0; add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);

        foreach (vecs[k]) begin
            reset = 1'(vecs[k].rst); playerWrite = 1'(vecs[k].pw);
            playerInput = AW'(vecs[k].pi); newGame = 1'(vecs[k].ng);
            isPlayer1Start = 1'(vecs[k].p1s);
            @(posedge ph1); #1;
            check($sformatf("v%0d.board", k), gBoard, vecs[k].board);
            check($sformatf("v%0d.accept", k), moveAccept, vecs[k].acc);
            check($sformatf("v%0d.error", k), moveError, vecs[k].err);
            check($sformatf("v%0d.player", k), currentPlayer, vecs[k].cp);
            check($sformatf("v%0d.done", k), gameIsDone, vecs[k].done);
            check($sformatf("v%0d.count", k), moveCount, vecs[k].cnt);
            check($sformatf("v%0d.winner", k), winner, vecs[k].win);
        end

        // random play against the model
        for (int k = 0; k < 4000; k++) begin
            bit r, pw, ng, p1;
            int pi;
            r  = (k == 0) || ($urandom_range(0, 299) == 0);
            pw = ($urandom_range(0, 99) < 70);
            pi = ($urandom_range(0, 99) < 85) ? int'($urandom_range(0, NN - 1))
                                              : int'($urandom_range(0, 15));
            ng = ($urandom_range(0, 3) == 0);
            p1 = 1'($urandom_range(0, 1));
            reset = r; playerWrite = pw; playerInput = AW'(pi); newGame = ng;
            isPlayer1Start = p1;
            mStep(r, pw, pi, ng, p1);
            @(posedge ph1); #1;
            check($sformatf("r%0d.board", k), gBoard, mBoard());
            check($sformatf("r%0d.accept", k), moveAccept, mAcc);
            check($sformatf("r%0d.error", k), moveError, mErr);
            check($sformatf("r%0d.player", k), currentPlayer, mP1);
            check($sformatf("r%0d.done", k), gameIsDone, mDone);
            check($sformatf("r%0d.count", k), moveCount, mCnt);
            check($sformatf("r%0d.winner", k), winner, mWin);
        end
        reset = 1'b0; playerWrite = 1'b0;

        // N=4 instance
        reset4 = 1'b1; step4(0, 0); step4(0, 0);
        check("n4.resetBoard", board4, 0);
        reset4 = 1'b0;
`ifdef GAME_MOVE_TIMEOUT_EN
        step4(0, 0);
        check("n4.toStartP1", cp4, 1);
        for (int i = 1; i <= 7; i++) begin
            step4(0, 0);
            check($sformatf("n4.noTimeout%0d", i), err4, 0);
        end
        step4(0, 0);
        check("n4.timeoutErr", err4, 1);
        check("n4.timeoutTurn", cp4, 0);
        check("n4.timeoutBoard", board4, 0);
        step4(0, 0);
        check("n4.timeoutPulse", err4, 0);
        reset4 = 1'b1; step4(0, 0); reset4 = 1'b0;
`endif
        step4(0, 0);
        check("n4.startP1", cp4, 1);
        begin
            int mv4[7];
            mv4 = '{0, 1, 4, 2, 8, 3, 12};
            for (int k = 0; k < 7; k++) begin
                step4(1, mv4[k]);
                check($sformatf("n4.accept%0d", k), acc4, 1);
                step4(0, 0);
                check($sformatf("n4.done%0d", k), done4, (k == 6) ? 1 : 0);
            end
        end
        check("n4.winner", win4, 2'b10);
        check("n4.count", cnt4, 7);
        check("n4.column", {board4[25:24], board4[17:16], board4[9:8], board4[1:0]}, 8'b10101010);
        check("n4.oCells", {board4[7:6], board4[5:4], board4[3:2]}, 6'b111111);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
